// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
//   - ALU control codes (AND/OR/ADD/SUB) and their width
//   - ALUOp encodings issued by decode
//   - funct3 values the sequencer recognises
//   - FSM state encoding
package alu_op_sequencer_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned F3_W    = 3;

  // ALU control codes
  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;

  // ALUOp encodings
  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_RSVD   = 2'b11;

  // funct3 values
  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;
  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : alu_op_sequencer_pkg

// File: rtl/alu_op_sequencer_ctrl_decode.sv
// alu_ctrl_decode: combinational translation of (aluop, funct3, funct7b5)
// into the ALU control code plus branch-type flags.
// Optional macro ALU_ILLEGAL_OP_EN adds the 'illegal' output.
// Ports:
//   aluop, funct3, funct7b5   request fields
//   ctrl                      ALU control code
//   is_branch_eq/is_branch_ne branch-compare flavour (aluop 01 only)
//   illegal                   (ALU_ILLEGAL_OP_EN) reserved aluop or unknown R-type funct3
module alu_ctrl_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [F3_W-1:0]    funct3,
  input  logic               funct7b5,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               is_branch_eq,
`ifdef ALU_ILLEGAL_OP_EN
  output logic               illegal,
`endif
  output logic               is_branch_ne
);

  // Control code and branch flavour; anything unrecognised falls back to ADD.
  always_comb begin
    ctrl         = CTRL_ADD;
    is_branch_eq = 1'b0;
    is_branch_ne = 1'b0;
    unique case (aluop)
      ALUOP_MEM: ctrl = CTRL_ADD;
      ALUOP_BRANCH: begin
        ctrl         = CTRL_SUB;
        is_branch_eq = (funct3 == F3_BEQ);
        is_branch_ne = (funct3 == F3_BNE);
      end
      ALUOP_RTYPE: begin
        unique case (funct3)
          F3_ADD:  ctrl = funct7b5 ? CTRL_SUB : CTRL_ADD;
          F3_AND:  ctrl = CTRL_AND;
          F3_OR:   ctrl = CTRL_OR;
          default: ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
  end

`ifdef ALU_ILLEGAL_OP_EN
  // Flag requests that executed only because of the ADD fallback.
  always_comb begin
    illegal = 1'b0;
    if (aluop == ALUOP_RSVD) begin
      illegal = 1'b1;
    end else if (aluop == ALUOP_RTYPE) begin
      illegal = !((funct3 == F3_ADD) || (funct3 == F3_AND) || (funct3 == F3_OR));
    end
  end
`endif

endmodule : alu_ctrl_decode

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts an ALU request over valid/ready, drives the
// external combinational ALU for exactly one cycle, captures result/zero and
// returns them with a branch decision over a second valid/ready handshake.
// Optional macro ALU_ILLEGAL_OP_EN adds output out_illegal.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            request handshake
//   in_aluop/in_funct3/in_funct7b5/in_a/in_b  request payload
//   alu_a/alu_b/alu_ctrl         to ALU (quiet/zero outside EXEC)
//   alu_result/alu_zero          from ALU
//   out_valid/out_ready          response handshake
//   out_result/out_zero/out_branch  response payload
//   out_illegal                  (ALU_ILLEGAL_OP_EN) request used ADD fallback
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALUOP_W-1:0]  in_aluop,
  input  logic [F3_W-1:0]     in_funct3,
  input  logic                in_funct7b5,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic                out_zero,
`ifdef ALU_ILLEGAL_OP_EN
  output logic                out_illegal,
`endif
  output logic                out_branch
);

  state_t state_q, state_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_beq;
  logic              dec_bne;

  // Decoded request attributes held across EXEC for the response.
  logic req_beq_q, req_bne_q;

  // Next values of the registered outputs.
  logic              in_ready_d;
  logic              out_valid_d;
  logic [XLEN-1:0]   alu_a_d, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_d;
  logic              accept_c;
  logic              capture_c;

`ifdef ALU_ILLEGAL_OP_EN
  logic dec_illegal;
  logic req_illegal_q;
`endif

  alu_ctrl_decode u_decode (
    .aluop        (in_aluop),
    .funct3       (in_funct3),
    .funct7b5     (in_funct7b5),
    .ctrl         (dec_ctrl),
    .is_branch_eq (dec_beq),
`ifdef ALU_ILLEGAL_OP_EN
    .illegal      (dec_illegal),
`endif
    .is_branch_ne (dec_bne)
  );

  // Next-state and next-output logic. Decoding happens on the live inputs at
  // the accept edge so the ALU bus is already valid during the EXEC cycle.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_ctrl_d  = CTRL_AND;
    accept_c    = 1'b0;
    capture_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture_c = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    if (accept_c) begin
      alu_a_d    = in_a;
      alu_b_d    = in_b;
      alu_ctrl_d = dec_ctrl;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= CTRL_AND;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_branch <= 1'b0;
      req_beq_q  <= 1'b0;
      req_bne_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_ctrl  <= alu_ctrl_d;
      if (accept_c) begin
        req_beq_q <= dec_beq;
        req_bne_q <= dec_bne;
      end
      if (capture_c) begin
        out_result <= alu_result;
        out_zero   <= alu_zero;
        out_branch <= (req_beq_q & alu_zero) | (req_bne_q & ~alu_zero);
      end
    end
  end

`ifdef ALU_ILLEGAL_OP_EN
  // Illegal flag travels with the request and is published with the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_illegal_q <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      if (accept_c) begin
        req_illegal_q <= dec_illegal;
      end
      if (capture_c) begin
        out_illegal <= req_illegal_q;
      end
    end
  end
`endif

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and
// reference model. Build with +define+ALU_ILLEGAL_OP_EN to cover out_illegal.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_branch;
`ifdef ALU_ILLEGAL_OP_EN
  logic        out_illegal;
`endif

  int checks = 0;
  int passed = 0;
  int resp_count = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_a        (in_a),
    .in_b        (in_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
`ifdef ALU_ILLEGAL_OP_EN
    .out_illegal (out_illegal),
`endif
    .out_branch  (out_branch)
  );

  // Behavioural ALU sitting outside the block under test.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Response handshakes actually completed.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) resp_count <= resp_count + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd2) begin
      if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
      if (f3 == 3'd7) return 4'b0000;
      if (f3 == 3'd6) return 4'b0001;
    end
    return 4'b0010;
  endfunction

  function automatic logic [31:0] m_result(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [3:0] c;
    c = m_ctrl(op, f3, f7);
    if (c == 4'b0110) return a - b;
    if (c == 4'b0000) return a & b;
    if (c == 4'b0001) return a | b;
    return a + b;
  endfunction

  function automatic logic m_branch(input logic [1:0] op, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
    if (op != 2'd1) return 1'b0;
    if (f3 == 3'd0) return a == b;
    if (f3 == 3'd1) return a != b;
    return 1'b0;
  endfunction

  function automatic logic m_illegal(input logic [1:0] op, input logic [2:0] f3);
    if (op == 2'd3) return 1'b1;
    if (op == 2'd2) return !(f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7);
    return 1'b0;
  endfunction

  // ---------------- tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_aluop = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_a = '0; in_b = '0;
    cycle(); cycle();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if ({out_result, out_zero, out_branch} !== 34'd0)
      $display("FAIL reset_out_regs: got %h/%b/%b expected 0", out_result, out_zero, out_branch); else passed++;
    checks++; if ({alu_a, alu_b, alu_ctrl} !== 68'd0)
      $display("FAIL reset_alu_bus: got %h/%h/%b expected 0", alu_a, alu_b, alu_ctrl); else passed++;
`ifdef ALU_ILLEGAL_OP_EN
    checks++; if (out_illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", out_illegal); else passed++;
`endif
  endtask

  // Full transaction: accept, EXEC cycle, DONE held 'hold' cycles, consume.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    int n;
    er = m_result(op, f3, f7, a, b);
    n = 0;
    while (!in_ready && n < 20) begin cycle(); n++; end
    checks++; if (in_ready !== 1'b1) $display("FAIL op_wait_ready: timeout in_ready=%b expected 1", in_ready); else passed++;
    in_valid = 1'b1; in_aluop = op; in_funct3 = f3; in_funct7b5 = f7; in_a = a; in_b = b;
    cycle();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    // EXEC
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL exec_handshake: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid); else passed++;
    checks++; if (alu_ctrl !== m_ctrl(op, f3, f7) || alu_a !== a || alu_b !== b)
      $display("FAIL exec_alu_bus op=%0d f3=%0d: got ctrl=%b a=%h b=%h expected ctrl=%b a=%h b=%h",
               op, f3, alu_ctrl, alu_a, alu_b, m_ctrl(op, f3, f7), a, b); else passed++;
    cycle();
    // DONE, possibly held by back-pressure
    for (int h = 0; h <= hold; h++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL done_handshake: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready); else passed++;
      checks++; if (out_result !== er || out_zero !== (er == 32'd0) || out_branch !== m_branch(op, f3, a, b))
        $display("FAIL done_result op=%0d f3=%0d f7=%b a=%h b=%h: got %h z=%b br=%b expected %h z=%b br=%b",
                 op, f3, f7, a, b, out_result, out_zero, out_branch, er, (er == 32'd0), m_branch(op, f3, a, b));
      else passed++;
      checks++; if ({alu_a, alu_b, alu_ctrl} !== 68'd0)
        $display("FAIL done_quiet_bus: got %h/%h/%b expected 0", alu_a, alu_b, alu_ctrl); else passed++;
`ifdef ALU_ILLEGAL_OP_EN
      checks++; if (out_illegal !== m_illegal(op, f3))
        $display("FAIL done_illegal: got %b expected %b", out_illegal, m_illegal(op, f3)); else passed++;
`endif
      if (h < hold) cycle();
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_consume: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_directed();
    run_op(2'b00, 3'b000, 1'b0, 32'd5, 32'd7, 0);
    run_op(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, 0);
    run_op(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234, 0);
    run_op(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1235, 0);
    run_op(2'b01, 3'b100, 1'b0, 32'h1, 32'h1, 0);
    run_op(2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(2'b10, 3'b110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(2'b10, 3'b000, 1'b1, 32'd3, 32'd5, 0);
    run_op(2'b00, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b11, 3'b000, 1'b0, 32'd1, 32'd2, 0);
    run_op(2'b10, 3'b011, 1'b1, 32'd10, 32'd20, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b,
             $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    int start;
    int n;
    start = resp_count;
    in_valid = 1'b1; in_aluop = 2'b00; in_funct3 = 3'b000; in_funct7b5 = 1'b0; in_a = 32'd100; in_b = 32'd23;
    cycle();                 // accept
    in_a = 32'd1; in_b = 32'd1;
    cycle();                 // now DONE; in_valid still asserted, must be ignored
    for (int h = 0; h < 5; h++) begin
      if (h == 2) begin in_valid = 1'b1; in_aluop = 2'b10; in_funct3 = 3'b111; end
      else in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'd123)
        $display("FAIL hold_stable: got valid=%b ready=%b result=%h expected 1/0/0000007b",
                 out_valid, in_ready, out_result); else passed++;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n = 0;
    while (n < 3) begin cycle(); n++; end
    checks++; if (resp_count !== start + 1)
      $display("FAIL hold_resp_count: got %0d expected %0d", resp_count - start, 1); else passed++;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_ctrl !== 4'b0000)
      $display("FAIL hold_back_idle: got valid=%b ready=%b ctrl=%b expected 0/1/0000",
               out_valid, in_ready, alu_ctrl); else passed++;
  endtask

  task automatic test_reset_mid_op(input bit in_done);
    int start;
    start = resp_count;
    in_valid = 1'b1; in_aluop = 2'b01; in_funct3 = 3'b000; in_funct7b5 = 1'b0; in_a = 32'd9; in_b = 32'd9;
    cycle();
    in_valid = 1'b0;
    if (in_done) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_mid_handshake done=%0d: got ready=%b valid=%b expected 1/0", in_done, in_ready, out_valid);
    else passed++;
    checks++; if ({out_result, out_zero, out_branch, alu_a, alu_b, alu_ctrl} !== 102'd0)
      $display("FAIL rst_mid_outputs done=%0d: got %h/%b/%b/%h/%h/%b expected 0", in_done,
               out_result, out_zero, out_branch, alu_a, alu_b, alu_ctrl); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b0;
    checks++; if (resp_count !== start || out_valid !== 1'b0)
      $display("FAIL rst_mid_no_resp done=%0d: got count=%0d valid=%b expected 0/0", in_done,
               resp_count - start, out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_op(1'b0);
    test_reset_mid_op(1'b1);
    test_random();
    run_op(2'b00, 3'b000, 1'b0, 32'd40, 32'd2, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_alu_op_sequencer
